// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a synchronized lock,
// qualifies it for a stable window and then releases the PLL-domain reset.
module pll_lock_sequencer #(
  parameter int RESET_HOLD    = 16,
  parameter int LOCK_TIMEOUT  = 4800,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clock_in,
  input  logic       resetb,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] relock_count
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [15:0] HOLD_LAST    = 16'(RESET_HOLD - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic        r_sync1;
  logic        r_sync2;
  logic        w_locked_s;
  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [3:0]  r_retry;
  logic [3:0]  w_retry_next;
  logic [3:0]  w_retry_inc;
  logic [7:0]  r_relock;
  logic [7:0]  w_relock_next;
  logic        r_pll_resetb;
  logic        r_sys_reset_n;
  logic        r_ready;
  logic        r_fault;

  assign w_locked_s = r_sync2;

  // Two-flop synchronizer for the asynchronous PLL lock flag.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they change in the same cycle the state does.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      r_state       <= S_RESET_PLL;
      r_cnt         <= 16'd0;
      r_retry       <= 4'd0;
      r_relock      <= 8'd0;
      r_pll_resetb  <= 1'b0;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_cnt_next;
      r_retry       <= w_retry_next;
      r_relock      <= w_relock_next;
      r_pll_resetb  <= (w_next_state == S_WAIT_LOCK) || (w_next_state == S_STABLE) ||
                       (w_next_state == S_RUN);
      r_sys_reset_n <= (w_next_state == S_RUN);
      r_ready       <= (w_next_state == S_RUN);
      r_fault       <= (w_next_state == S_FAULT);
    end
  end

  // Next-state logic; restart overrides every lock or timeout event.
  always_comb begin
    w_next_state  = r_state;
    w_retry_next  = r_retry;
    w_relock_next = r_relock;
    w_retry_inc   = r_retry + 4'd1;
    if (restart) begin
      w_next_state = S_RESET_PLL;
      w_retry_next = 4'd0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == HOLD_LAST) begin
            w_next_state = S_WAIT_LOCK;
          end else begin
            w_next_state = S_RESET_PLL;
          end
        end
        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_next_state = S_STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_retry_next = w_retry_inc;
            w_next_state = (w_retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
          end else begin
            w_next_state = S_WAIT_LOCK;
          end
        end
        S_STABLE: begin
          if (!w_locked_s) begin
            w_next_state = S_WAIT_LOCK;
          end else if (r_cnt == STABLE_LAST) begin
            w_next_state = S_RUN;
            w_retry_next = 4'd0;
          end else begin
            w_next_state = S_STABLE;
          end
        end
        S_RUN: begin
          if (!w_locked_s) begin
            w_next_state  = S_RESET_PLL;
            w_relock_next = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;
          end else begin
            w_next_state = S_RUN;
          end
        end
        S_FAULT: begin
          w_next_state = S_FAULT;
        end
        default: begin
          w_next_state = S_RESET_PLL;
        end
      endcase
    end
  end

  // Cycle counter restarts on every state entry (restart counts as re-entry).
  always_comb begin
    w_cnt_next = r_cnt;
    if (restart || (w_next_state != r_state)) begin
      w_cnt_next = 16'd0;
    end else if (r_cnt != 16'hFFFF) begin
      w_cnt_next = r_cnt + 16'd1;
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  assign pll_resetb   = r_pll_resetb;
  assign sys_reset_n  = r_sys_reset_n;
  assign ready        = r_ready;
  assign fault        = r_fault;
  assign relock_count = r_relock;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed bring-up scenarios plus randomized PLL
// behaviour, every cycle compared against a phase/elapsed-time reference model.
module tb_pll_lock_sequencer;

  localparam int RH = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int P_RST = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN = 3;
  localparam int P_FLT = 4;

  logic       clock_in = 1'b0;
  logic       resetb;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [7:0] relock_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_phase, m_age, m_tries, m_relocks, m_losses;
  logic m_hist0, m_hist1;
  int emu_cd;
  int n;

  pll_lock_sequencer #(
    .RESET_HOLD(RH), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .clock_in(clock_in), .resetb(resetb), .locked(locked), .restart(restart),
    .pll_resetb(pll_resetb), .sys_reset_n(sys_reset_n), .ready(ready),
    .fault(fault), .relock_count(relock_count)
  );

  always #5 clock_in = ~clock_in;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RST; m_age = 0; m_tries = 0; m_relocks = 0;
    m_hist0 = 1'b0; m_hist1 = 1'b0;
  endtask

  // One clock of the reference: lock seen two edges late, elapsed time per phase.
  task automatic model_step(input logic lk, input logic rs);
    logic ls;
    int nxt;
    ls = m_hist1; m_hist1 = m_hist0; m_hist0 = lk;
    nxt = m_phase;
    if (rs) begin
      nxt = P_RST; m_tries = 0;
    end else if (m_phase == P_RST) begin
      if (m_age + 1 >= RH) nxt = P_WAIT;
    end else if (m_phase == P_WAIT) begin
      if (ls) nxt = P_STAB;
      else if (m_age + 1 >= LT) begin
        m_tries++;
        nxt = (m_tries >= MR) ? P_FLT : P_RST;
      end
    end else if (m_phase == P_STAB) begin
      if (!ls) nxt = P_WAIT;
      else if (m_age + 1 >= SC) begin nxt = P_RUN; m_tries = 0; end
    end else if (m_phase == P_RUN) begin
      if (!ls) begin
        nxt = P_RST; m_losses++;
        if (m_relocks < 255) m_relocks++;
      end
    end
    m_age = (rs || nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  task automatic compare_all();
    check_eq("pll_resetb", 16'(pll_resetb), 16'(m_phase == P_WAIT || m_phase == P_STAB || m_phase == P_RUN));
    check_eq("sys_reset_n", 16'(sys_reset_n), 16'(m_phase == P_RUN));
    check_eq("ready", 16'(ready), 16'(m_phase == P_RUN));
    check_eq("fault", 16'(fault), 16'(m_phase == P_FLT));
    check_eq("relock_count", 16'(relock_count), 16'(m_relocks));
  endtask

  task automatic tick();
    @(posedge clock_in);
    if (!resetb) model_reset();
    else model_step(locked, restart);
    @(negedge clock_in);
    compare_all();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic wait_pll_high();
    int k;
    k = 0;
    while (!pll_resetb && k < 100) begin tick(); k++; end
    check_eq("pll_up_wait", 16'(pll_resetb), 16'd1);
  endtask

  // Randomized PLL emulator: lock after a random delay, random dropouts, rare restarts.
  task automatic run_random(input int max_cyc, input int glitch_pct, input int rs_on,
                            input int long_on, input int stop_losses);
    int c;
    c = 0;
    while (c < max_cyc && (stop_losses == 0 || m_losses < stop_losses)) begin
      tick();
      c++;
      if (!pll_resetb) begin
        locked = 1'b0;
        emu_cd = (long_on != 0 && $urandom_range(0, 9) == 0) ? 60 : int'($urandom_range(1, 30));
      end else if (emu_cd > 0) begin
        emu_cd--;
        if (emu_cd == 0) locked = 1'b1;
      end else if (locked && int'($urandom_range(0, 99)) < glitch_pct) begin
        locked = 1'b0;
        emu_cd = $urandom_range(1, 4);
      end else if (!locked) begin
        emu_cd = $urandom_range(1, 30);
      end
      restart = (rs_on != 0 && $urandom_range(0, 149) == 0);
    end
    restart = 1'b0;
    if (stop_losses != 0) check_eq("loss_budget", 16'(m_losses >= stop_losses), 16'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 1'b0; locked = 1'b0; restart = 1'b0; emu_cd = 0; m_losses = 0;
    #1;
    model_reset();
    compare_all();
    tick(); tick();
    resetb = 1'b1;

    // clean lock: lock 5 cycles after pll_resetb rises
    wait_pll_high();
    repeat (4) tick();
    locked = 1'b1;
    tick();
    n = 0;
    while (!ready && n < 50) begin tick(); n++; end
    check_eq("clean_lock_latency", 16'(n), 16'd10);

    // lock loss in RUN
    repeat (3) tick();
    locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ready && n < 20);
    check_eq("loss_latency", 16'(n), 16'd3);
    check_eq("relock_one", 16'(relock_count), 16'd1);
    n = 0;
    while (!pll_resetb && n < 20) begin n++; tick(); end
    check_eq("relock_reset_len", 16'(n), 16'd4);
    repeat (4) tick();
    locked = 1'b1;
    n = 0;
    while (!ready && n < 60) begin tick(); n++; end
    check_eq("relock_run", 16'(ready), 16'd1);

    // one-cycle glitch at STABLE cycle 5
    locked = 1'b0;
    pulse_restart();
    wait_pll_high();
    repeat (4) tick();
    locked = 1'b1;
    repeat (6) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    n = 0;
    while (!ready && n < 50) begin tick(); n++; end
    check_eq("glitch_latency", 16'(n), 16'd11);

    // asynchronous reset in RUN
    #2 resetb = 1'b0;
    #1 model_reset();
    compare_all();
    locked = 1'b0;
    tick(); tick();
    resetb = 1'b1;

    // no lock -> FAULT after two rounds
    n = 0;
    while (!fault && n < 200) begin tick(); n++; end
    check_eq("fault_latency", 16'(n), 16'd72);
    check_eq("fault_pll_low", 16'(pll_resetb), 16'd0);
    pulse_restart();
    n = 0;
    while (!pll_resetb && n < 20) begin n++; tick(); end
    check_eq("restart_reset_len", 16'(n), 16'd4);

    // restart coinciding with the final timeout clears the retry count
    pulse_restart();
    repeat (71) tick();
    pulse_restart();
    check_eq("restart_beats_timeout", 16'(fault), 16'd0);
    n = 0;
    while (!fault && n < 200) begin tick(); n++; end
    check_eq("fault_after_restart", 16'(n), 16'd72);

    // restart coinciding with synchronized lock in WAIT_LOCK
    pulse_restart();
    wait_pll_high();
    locked = 1'b1;
    tick(); tick();
    pulse_restart();
    check_eq("restart_beats_lock", 16'(pll_resetb), 16'd0);
    locked = 1'b0;

    // randomized operation, then drive relock_count into saturation
    emu_cd = 0;
    run_random(3000, 3, 1, 1, 0);
    m_losses = 0;
    run_random(20000, 8, 0, 0, 300);
    check_eq("relock_saturated", 16'(relock_count), 16'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
